// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and lane helpers for the MEM stage
package mem_stage_pkg;

  typedef enum logic {OP_LD = 1'b0, OP_ST = 1'b1} mem_op_e;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD} mem_size_e;

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD, DONE, ERR} state_e;

  // 1 = byte NOT written; callers truncate to their lane count
  function automatic logic [7:0] lane_mask(mem_size_e size, logic [2:0] offset);
    logic [7:0] ones;
    case (size)
      SZ_BYTE: ones = 8'h01;
      SZ_HALF: ones = 8'h03;
      SZ_WORD: ones = 8'h0F;
      default: ones = 8'hFF;
    endcase
    return ~(ones << offset);
  endfunction

  // dword accesses only exist on a 64-bit data path
  function automatic logic misaligned(mem_size_e size, logic [2:0] lo, logic wide);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = |lo[1:0];
      default: bad = !wide || (|lo);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - DDR3 application-interface bundle between MEM stage and DDR IP
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 29,
  parameter int DATA_W = 32
);
  logic                  cmd_rdy;
  logic                  cmd_en;
  logic                  cmd;
  logic [ADDR_W-1:0]     addr;
  logic                  wr_rdy;
  logic                  wr_en;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_mask;
  logic                  wr_end;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  rd_end;

  modport master (
    input  cmd_rdy, wr_rdy, rd_data, rd_valid, rd_end,
    output cmd_en, cmd, addr, wr_en, wr_data, wr_mask, wr_end
  );

  modport slave (
    output cmd_rdy, wr_rdy, rd_data, rd_valid, rd_end,
    input  cmd_en, cmd, addr, wr_en, wr_data, wr_mask, wr_end
  );
endinterface

// File: rtl/mem_stage_ctrl_lane_align.sv
// rtl/mem_stage_ctrl_lane_align.sv - store lane shift/mask and load extract/extend
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  mem_size_e                      size,
  input  logic                           sgn,
  input  logic [$clog2(DATA_W/8)-1:0]    offset,
  input  logic [DATA_W-1:0]              st_data,
  output logic [DATA_W-1:0]              st_data_pos,
  output logic [DATA_W/8-1:0]            st_mask,
  input  logic [DATA_W-1:0]              ld_data,
  output logic [DATA_W-1:0]              ld_data_ext
);
  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);

  logic [OFF_W+2:0]  shamt;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              sbit;

  assign shamt       = {offset, 3'b000};
  assign st_data_pos = st_data << shamt;
  assign st_mask     = LANES'(lane_mask(size, 3'(offset)));
  assign shifted     = ld_data >> shamt;

  always_comb begin
    keep = '1;
    sbit = shifted[DATA_W-1];
    case (size)
      SZ_BYTE: begin keep = DATA_W'(8'hFF);         sbit = shifted[7];  end
      SZ_HALF: begin keep = DATA_W'(16'hFFFF);      sbit = shifted[15]; end
      SZ_WORD: begin keep = DATA_W'(32'hFFFF_FFFF); sbit = shifted[31]; end
      default: ;
    endcase
    ld_data_ext = (shifted & keep) | ((sgn && sbit) ? ~keep : '0);
  end
endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - V850 MEM stage: LD/ST to DDR3 app interface, one op in flight
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 29,
  parameter int DATA_W  = 32,
  parameter int DEST_W  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_op_i,
  input  logic [1:0]         req_size_i,
  input  logic               req_signed_i,
  input  logic [ADDR_W-1:0]  req_addr_i,
  input  logic [DATA_W-1:0]  req_wdata_i,
  input  logic [DEST_W-1:0]  req_dest_i,
  output logic               wb_valid_o,
  output logic [DATA_W-1:0]  wb_data_o,
  output logic [DEST_W-1:0]  wb_dest_o,
  output logic               err_o,
  mem_stage_ctrl_if.master   ddr
);
  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  mem_op_e             op_q;
  mem_size_e           size_q;
  logic                sgn_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rd_buf_q;
  logic [DEST_W-1:0]   dest_q;
  logic                cmd_done_q, wr_done_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                tmo_hit, cmd_en, wr_en, ld_done;
  logic [DATA_W-1:0]   st_pos, ld_ext;
  logic [LANES-1:0]    st_mask;
  logic                unused_rd_end;

  // single-beat reads: the end marker carries no extra information
  assign unused_rd_end = ddr.rd_end;
  assign tmo_hit       = (tmo_q == TMO_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cmd_en  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: if (req_valid_i) begin
        if (misaligned(mem_size_e'(req_size_i), req_addr_i[2:0], DATA_W == 64))
          state_d = ERR;
        else
          state_d = req_op_i ? WR_CMD : RD_CMD;
      end
      RD_CMD: begin
        cmd_en = 1'b1;
        if (ddr.cmd_rdy)  state_d = RD_WAIT;
        else if (tmo_hit) state_d = ERR;
      end
      RD_WAIT: begin
        if (ddr.rd_valid) state_d = DONE;
        else if (tmo_hit) state_d = ERR;
      end
      WR_CMD: begin
        // command and data strobes retire independently
        cmd_en = !cmd_done_q;
        wr_en  = !wr_done_q;
        if ((cmd_done_q || ddr.cmd_rdy) && (wr_done_q || ddr.wr_rdy)) state_d = DONE;
        else if (tmo_hit)                                              state_d = ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_LD;
      size_q     <= SZ_BYTE;
      sgn_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dest_q     <= '0;
      rd_buf_q   <= '0;
      cmd_done_q <= 1'b0;
      wr_done_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      cmd_done_q <= (state_q == WR_CMD) && (cmd_done_q || ddr.cmd_rdy);
      wr_done_q  <= (state_q == WR_CMD) && (wr_done_q || ddr.wr_rdy);
      if (state_d != state_q || !(state_q inside {RD_CMD, RD_WAIT, WR_CMD}))
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + TMO_W'(1);
      if (state_q == IDLE && req_valid_i) begin
        op_q    <= mem_op_e'(req_op_i);
        size_q  <= mem_size_e'(req_size_i);
        sgn_q   <= req_signed_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        dest_q  <= req_dest_i;
      end
      if (state_q == RD_WAIT && ddr.rd_valid)
        rd_buf_q <= ddr.rd_data;
    end
  end

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size        (size_q),
    .sgn         (sgn_q),
    .offset      (addr_q[OFF_W-1:0]),
    .st_data     (wdata_q),
    .st_data_pos (st_pos),
    .st_mask     (st_mask),
    .ld_data     (rd_buf_q),
    .ld_data_ext (ld_ext)
  );

  assign req_ready_o  = (state_q == IDLE);
  assign ddr.cmd_en   = cmd_en;
  assign ddr.cmd      = (state_q == WR_CMD);
  assign ddr.addr     = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign ddr.wr_en    = wr_en;
  assign ddr.wr_end   = wr_en;
  assign ddr.wr_data  = wr_en ? st_pos : '0;
  assign ddr.wr_mask  = wr_en ? st_mask : '0;

  assign ld_done    = (state_q == DONE) && (op_q == OP_LD);
  assign wb_valid_o = (state_q == DONE) || (state_q == ERR);
  assign err_o      = (state_q == ERR);
  assign wb_data_o  = ld_done ? ld_ext : '0;
  assign wb_dest_o  = ld_done ? dest_q : '0;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed bench for mem_stage_ctrl (default and TIMEOUT=8 instances)
module tb_mem_stage_ctrl;
  localparam int ADDR_W = 29;
  localparam int DATA_W = 32;
  localparam int DEST_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid = 1'b0, req_op = 1'b0, req_signed = 1'b0;
  logic [1:0]        req_size = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [DEST_W-1:0] req_dest = '0;
  logic              cmd_rdy = 1'b0, wr_rdy = 1'b0, rd_valid = 1'b0, rd_end = 1'b0;
  logic [DATA_W-1:0] rd_data = '0;

  logic              req_ready, wb_valid, err;
  logic [DATA_W-1:0] wb_data;
  logic [DEST_W-1:0] wb_dest;
  logic              req_ready8, wb_valid8, err8;
  logic [DATA_W-1:0] wb_data8;
  logic [DEST_W-1:0] wb_dest8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if0 ();
  mem_stage_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if8 ();

  assign if0.cmd_rdy  = cmd_rdy;
  assign if0.wr_rdy   = wr_rdy;
  assign if0.rd_data  = rd_data;
  assign if0.rd_valid = rd_valid;
  assign if0.rd_end   = rd_end;
  assign if8.cmd_rdy  = cmd_rdy;
  assign if8.wr_rdy   = wr_rdy;
  assign if8.rd_data  = rd_data;
  assign if8.rd_valid = rd_valid;
  assign if8.rd_end   = rd_end;

  mem_stage_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEST_W(DEST_W), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_dest_i(req_dest),
    .wb_valid_o(wb_valid), .wb_data_o(wb_data), .wb_dest_o(wb_dest), .err_o(err),
    .ddr(if0)
  );

  mem_stage_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEST_W(DEST_W), .TIMEOUT(8)) dut8 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready8), .req_op_i(req_op),
    .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_dest_i(req_dest),
    .wb_valid_o(wb_valid8), .wb_data_o(wb_data8), .wb_dest_o(wb_dest8), .err_o(err8),
    .ddr(if8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // presents one op for a single accept edge; returns 1 time unit after that edge
  task automatic issue(input logic op, input logic [1:0] size, input logic sgn,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                       input logic [DEST_W-1:0] dest);
    req_op = op; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_dest = dest;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_ld(input string tag, input logic [ADDR_W-1:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [DEST_W-1:0] dest,
                       input logic [31:0] word, input logic [31:0] exp);
    cmd_rdy = 1'b1;
    check({tag, "_ready_idle"}, req_ready, 1);
    issue(1'b0, size, sgn, addr, '0, dest);
    check({tag, "_cmd_en"}, if0.cmd_en, 1);
    check({tag, "_cmd"}, if0.cmd, 0);
    check({tag, "_ddr_addr"}, if0.addr, {addr[ADDR_W-1:2], 2'b00});
    check({tag, "_ready_busy"}, req_ready, 0);
    step();
    rd_valid = 1'b1;
    rd_data  = word;
    step();
    rd_valid = 1'b0;
    check({tag, "_wb_valid"}, wb_valid, 1);
    check({tag, "_wb_data"}, wb_data, exp);
    check({tag, "_wb_dest"}, wb_dest, dest);
    check({tag, "_err"}, err, 0);
    step();
    check({tag, "_wb_pulse_end"}, wb_valid, 0);
  endtask

  initial begin
    int err8_at;
    rst = 1'b1;
    step();
    check("rst_ready", req_ready, 1);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_err", err, 0);
    check("rst_cmd_en", if0.cmd_en, 0);
    check("rst_wr_en", if0.wr_en, 0);
    check("rst_wb_data", wb_data, 0);
    step();
    rst = 1'b0;
    step();
    check("ready_after_rst", req_ready, 1);

    do_ld("ldb_s", 'h102, 2'd0, 1'b1, 5'd7,  32'h1180_3344, 32'hFFFF_FF80);
    do_ld("ldh_u", 'h102, 2'd1, 1'b0, 5'd12, 32'hBEEF_1234, 32'h0000_BEEF);
    do_ld("ldh_s", 'h102, 2'd1, 1'b1, 5'd12, 32'hBEEF_1234, 32'hFFFF_BEEF);
    do_ld("ldb_u", 'h101, 2'd0, 1'b0, 5'd1,  32'h1180_3344, 32'h0000_0033);
    do_ld("ldw",   'h104, 2'd2, 1'b1, 5'd31, 32'h8000_0001, 32'h8000_0001);

    // store byte, both handshakes immediate
    cmd_rdy = 1'b1; wr_rdy = 1'b1;
    issue(1'b1, 2'd0, 1'b0, 'h203, 32'h0000_00AB, 5'd9);
    check("stb_cmd_en", if0.cmd_en, 1);
    check("stb_cmd", if0.cmd, 1);
    check("stb_addr", if0.addr, 'h200);
    check("stb_wr_en", if0.wr_en, 1);
    check("stb_wr_end", if0.wr_end, 1);
    check("stb_wr_data", if0.wr_data, 32'hAB00_0000);
    check("stb_wr_mask", if0.wr_mask, 4'b0111);
    step();
    check("stb_wb_valid", wb_valid, 1);
    check("stb_wb_dest", wb_dest, 0);
    check("stb_wb_data", wb_data, 0);
    check("stb_err", err, 0);
    check("stb_wr_en_off", if0.wr_en, 0);
    step();

    // store half, write data accepted one cycle after the command
    cmd_rdy = 1'b1; wr_rdy = 1'b0;
    issue(1'b1, 2'd1, 1'b0, 'h106, 32'h0000_1234, 5'd0);
    check("sth_wr_data", if0.wr_data, 32'h1234_0000);
    check("sth_wr_mask", if0.wr_mask, 4'b0011);
    check("sth_wr_en", if0.wr_en, 1);
    step();
    check("sth_cmd_dropped", if0.cmd_en, 0);
    check("sth_wr_held", if0.wr_en, 1);
    check("sth_no_wb_yet", wb_valid, 0);
    wr_rdy = 1'b1;
    step();
    wr_rdy = 1'b0;
    check("sth_wb_valid", wb_valid, 1);
    step();

    // misaligned word load
    cmd_rdy = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 'h101, '0, 5'd4);
    check("mis_cmd_en", if0.cmd_en, 0);
    check("mis_wb_valid", wb_valid, 1);
    check("mis_err", err, 1);
    check("mis_wb_data", wb_data, 0);
    step();
    check("mis_err_end", err, 0);
    check("mis_wb_end", wb_valid, 0);
    check("mis_ready", req_ready, 1);

    // back-pressure: command not accepted for 10 cycles
    cmd_rdy = 1'b0;
    err8_at = 0;
    issue(1'b0, 2'd2, 1'b0, 'h300, '0, 5'd3);
    for (int i = 1; i <= 10; i++) begin
      check("bp_cmd_en", if0.cmd_en, 1);
      check("bp_ready", req_ready, 0);
      if (i == 8) check("bp8_cmd_en_held", if8.cmd_en, 1);
      if (i == 9) check("bp8_cmd_en_drop", if8.cmd_en, 0);
      if (err8 && err8_at == 0) err8_at = i;
      step();
    end
    check("bp8_err_cycle", err8_at, 9);
    cmd_rdy = 1'b1;
    step();
    rd_valid = 1'b1;
    rd_data  = 32'h0000_5A5A;
    step();
    rd_valid = 1'b0;
    check("bp_wb_valid", wb_valid, 1);
    check("bp_wb_data", wb_data, 32'h0000_5A5A);
    check("bp_err", err, 0);
    check("bp8_stale_ignored", wb_valid8, 0);
    step();

    // reset while waiting for read data
    cmd_rdy = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 'h400, '0, 5'd5);
    step();
    check("rs_in_wait", req_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    check("rs_ready_async", req_ready, 1);
    check("rs_wb_async", wb_valid, 0);
    step();
    rst = 1'b0;
    rd_valid = 1'b1;
    rd_data  = 32'hDEAD_BEEF;
    step();
    rd_valid = 1'b0;
    check("rs_late_wb", wb_valid, 0);
    check("rs_late_ready", req_ready, 1);
    do_ld("rs_next", 'h404, 2'd2, 1'b0, 5'd6, 32'h0BAD_F00D, 32'h0BAD_F00D);

    // reset while both write strobes are pending
    cmd_rdy = 1'b0; wr_rdy = 1'b0;
    issue(1'b1, 2'd2, 1'b0, 'h500, 32'hCAFE_F00D, 5'd0);
    check("rw_wr_en", if0.wr_en, 1);
    check("rw_wr_data", if0.wr_data, 32'hCAFE_F00D);
    #2;
    rst = 1'b1;
    #1;
    check("rw_wr_en_async", if0.wr_en, 0);
    check("rw_cmd_en_async", if0.cmd_en, 0);
    check("rw_wr_data_async", if0.wr_data, 0);
    step();
    rst = 1'b0;
    step();
    check("rw_ready", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
